// File: rtl/pipeline_addsub.sv
// Pipelined chunked adder/subtractor with valid/ready backpressure and signed-overflow flag.
// Define PIPELINE_ADDSUB_SAT_EN to add i_sat and clamp o_sum on signed overflow.
module pipeline_addsub #(
  parameter int P_DATA_WIDTH = 16,
  parameter int P_STAGES     = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [P_DATA_WIDTH-1:0] i_a,
  input  logic [P_DATA_WIDTH-1:0] i_b,
  input  logic                    i_cin,
  input  logic                    i_sub,
`ifdef PIPELINE_ADDSUB_SAT_EN
  input  logic                    i_sat,
`endif
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [P_DATA_WIDTH-1:0] o_sum,
  output logic                    o_cout,
  output logic                    o_ovf
);

  localparam int W  = P_DATA_WIDTH;
  localparam int N  = P_STAGES;
  localparam int CW = (N > 0) ? (W / N) : W;

  generate
    if ((N < 1) || (N > W)) begin : g_stage_range_chk
      $error("pipeline_addsub: P_STAGES must be in 1..P_DATA_WIDTH");
    end else if ((W % N) != 0) begin : g_stage_div_chk
      $error("pipeline_addsub: P_DATA_WIDTH must be divisible by P_STAGES");
    end
  endgenerate

  // Per-stage state: partial result, delayed operands, chunk carry and valid bit.
  logic [W-1:0] sum_q [N];
  logic [W-1:0] sum_d [N];
  logic [W-1:0] a_q   [N];
  logic [W-1:0] a_d   [N];
  logic [W-1:0] b_q   [N];
  logic [W-1:0] b_d   [N];
  logic         cy_q  [N];
  logic         cy_d  [N];
  logic         vld_q [N];
  logic         vld_d [N];
`ifdef PIPELINE_ADDSUB_SAT_EN
  logic         sat_q [N];
  logic         sat_d [N];
`endif
  logic         ovf_q;
  logic         ovf_d;

  logic          en_s;
  logic [W-1:0]  op_a_s;
  logic [W-1:0]  op_b_s;
  logic [W-1:0]  lower_s;
  logic          carry_in_s;
  logic          chunk_c_s;
  logic [CW-1:0] chunk_s;
  logic          msb_cin_s;

  assign en_s = ~vld_q[N-1] | i_ready;

  // Next-state for every stage: one CW-bit chunk add per stage, carry rippled forward.
  always_comb begin
    op_a_s     = '0;
    op_b_s     = '0;
    lower_s    = '0;
    carry_in_s = 1'b0;
    chunk_c_s  = 1'b0;
    chunk_s    = '0;
    for (int k = 0; k < N; k++) begin
      if (k == 0) begin
        op_a_s     = i_a;
        op_b_s     = i_sub ? ~i_b : i_b;
        carry_in_s = i_sub ? 1'b1 : i_cin;
        lower_s    = '0;
        vld_d[k]   = i_valid;
`ifdef PIPELINE_ADDSUB_SAT_EN
        sat_d[k]   = i_sat;
`endif
      end else begin
        op_a_s     = a_q[k-1];
        op_b_s     = b_q[k-1];
        carry_in_s = cy_q[k-1];
        lower_s    = sum_q[k-1];
        vld_d[k]   = vld_q[k-1];
`ifdef PIPELINE_ADDSUB_SAT_EN
        sat_d[k]   = sat_q[k-1];
`endif
      end
      {chunk_c_s, chunk_s} = {1'b0, op_a_s[k*CW +: CW]} + {1'b0, op_b_s[k*CW +: CW]}
                           + {{CW{1'b0}}, carry_in_s};
      sum_d[k]             = lower_s;
      sum_d[k][k*CW +: CW] = chunk_s;
      cy_d[k]              = chunk_c_s;
      a_d[k]               = op_a_s;
      b_d[k]               = op_b_s;
    end
    // After the loop op_a_s/op_b_s hold the last stage's operands.
    msb_cin_s = op_a_s[W-1] ^ op_b_s[W-1] ^ sum_d[N-1][W-1];
    ovf_d     = msb_cin_s ^ cy_d[N-1];
`ifdef PIPELINE_ADDSUB_SAT_EN
    // Wrapped MSB=1 means positive overflow, so clamp to max positive; else to min negative.
    sum_d[N-1] = (sat_d[N-1] && ovf_d)
               ? (sum_d[N-1][W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}})
               : sum_d[N-1];
`endif
  end

  // Pipeline registers: synchronous clear, whole pipe advances only when en_s.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < N; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        cy_q[k]  <= 1'b0;
        vld_q[k] <= 1'b0;
`ifdef PIPELINE_ADDSUB_SAT_EN
        sat_q[k] <= 1'b0;
`endif
      end
      ovf_q <= 1'b0;
    end else if (en_s) begin
      for (int k = 0; k < N; k++) begin
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        cy_q[k]  <= cy_d[k];
        vld_q[k] <= vld_d[k];
`ifdef PIPELINE_ADDSUB_SAT_EN
        sat_q[k] <= sat_d[k];
`endif
      end
      ovf_q <= ovf_d;
    end
  end

  assign o_ready = en_s;
  assign o_valid = vld_q[N-1];
  assign o_sum   = sum_q[N-1];
  assign o_cout  = cy_q[N-1];
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_pipeline_addsub.sv
// Directed self-checking bench for pipeline_addsub (16-bit, 4 stages).
module tb_pipeline_addsub;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
`ifdef PIPELINE_ADDSUB_SAT_EN
  logic        sat;
`endif
  logic        valid_o;
  logic        ready_i;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  pipeline_addsub #(.P_DATA_WIDTH(16), .P_STAGES(4)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid_i),
    .o_ready (ready_o),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .i_sub   (sub),
`ifdef PIPELINE_ADDSUB_SAT_EN
    .i_sat   (sat),
`endif
    .o_valid (valid_o),
    .i_ready (ready_i),
    .o_sum   (sum),
    .o_cout  (cout),
    .o_ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    a = 16'h0000; b = 16'h0000; cin = 1'b0; sub = 1'b0;
`ifdef PIPELINE_ADDSUB_SAT_EN
    sat = 1'b0;
`endif
    tick();
    tick();
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    checks++;
    if ({cout, ovf, sum} !== 18'h0) begin
      errors++; $display("FAIL reset_outputs got cout=%b ovf=%b sum=%h exp 0 0 0000", cout, ovf, sum);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
  endtask

  task automatic test_add_ripple();
    valid_i = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0;
    tick();
    valid_i = 1'b0;
    tick();
    tick();
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL ripple_early got valid=%b exp 0", valid_o); end
    tick();
    checks++;
    if ({valid_o, cout, ovf, sum} !== {1'b1, 1'b0, 1'b0, 16'h0100}) begin
      errors++;
      $display("FAIL ripple_result got v=%b c=%b o=%b s=%h exp 1 0 0 0100", valid_o, cout, ovf, sum);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_sum;
    for (int t = 0; t < 13; t++) begin
      checks++;
      if (t >= 4 && t <= 11) begin
        exp_sum = 16'(t - 4);
        if ({valid_o, cout, ovf, sum} !== {1'b1, 1'b1, 1'b0, exp_sum}) begin
          errors++;
          $display("FAIL b2b_t%0d got v=%b c=%b o=%b s=%h exp 1 1 0 %h", t, valid_o, cout, ovf, sum, exp_sum);
        end
      end else begin
        if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_t%0d got valid=%b exp 0", t, valid_o); end
      end
      if (t < 8) begin
        valid_i = 1'b1; a = 16'(t); b = 16'hFFFF; cin = 1'b1; sub = 1'b0;
      end else begin
        valid_i = 1'b0;
      end
      tick();
    end
    drain();
  endtask

  task automatic test_subtract();
    logic [15:0] ta [3];
    logic [15:0] tb_ [3];
    logic        tc [3];
    logic        ts [3];
    logic [17:0] te [3];
    ta[0] = 16'h0003; tb_[0] = 16'h0005; tc[0] = 1'b0; ts[0] = 1'b1; te[0] = {1'b0, 1'b0, 16'hFFFE};
    ta[1] = 16'h8000; tb_[1] = 16'h0001; tc[1] = 1'b1; ts[1] = 1'b1; te[1] = {1'b1, 1'b1, 16'h7FFF};
    ta[2] = 16'h7FFF; tb_[2] = 16'h0001; tc[2] = 1'b0; ts[2] = 1'b0; te[2] = {1'b0, 1'b1, 16'h8000};
    for (int t = 0; t < 7; t++) begin
      if (t >= 4) begin
        checks++;
        if ({valid_o, cout, ovf, sum} !== {1'b1, te[t-4]}) begin
          errors++;
          $display("FAIL sub_ovf_%0d got v=%b c=%b o=%b s=%h exp v=1 {c,o,s}=%h", t - 4, valid_o, cout, ovf, sum, te[t-4]);
        end
      end
      if (t < 3) begin
        valid_i = 1'b1; a = ta[t]; b = tb_[t]; cin = tc[t]; sub = ts[t];
      end else begin
        valid_i = 1'b0;
      end
      tick();
    end
    sub = 1'b0;
    drain();
  endtask

  task automatic test_backpressure();
    logic [15:0] va [10];
    logic [15:0] vb [10];
    logic        vc [10];
    logic        vs [10];
    logic [16:0] ve [10];
    logic [16:0] exp_q [$];
    logic        held_valid;
    logic [15:0] held_sum;
    int          idx;
    int          got;
    int          t;
    va[0] = 16'h1234; vb[0] = 16'h1111; vc[0] = 1'b0; vs[0] = 1'b0; ve[0] = {1'b0, 16'h2345};
    va[1] = 16'hFFFF; vb[1] = 16'h0001; vc[1] = 1'b0; vs[1] = 1'b0; ve[1] = {1'b1, 16'h0000};
    va[2] = 16'h0F0F; vb[2] = 16'hF0F0; vc[2] = 1'b1; vs[2] = 1'b0; ve[2] = {1'b1, 16'h0000};
    va[3] = 16'h1000; vb[3] = 16'h0001; vc[3] = 1'b0; vs[3] = 1'b1; ve[3] = {1'b1, 16'h0FFF};
    va[4] = 16'h0001; vb[4] = 16'h0002; vc[4] = 1'b0; vs[4] = 1'b1; ve[4] = {1'b0, 16'hFFFF};
    va[5] = 16'hABCD; vb[5] = 16'h0000; vc[5] = 1'b1; vs[5] = 1'b0; ve[5] = {1'b0, 16'hABCE};
    va[6] = 16'h8000; vb[6] = 16'h8000; vc[6] = 1'b0; vs[6] = 1'b0; ve[6] = {1'b1, 16'h0000};
    va[7] = 16'h5555; vb[7] = 16'hAAAA; vc[7] = 1'b0; vs[7] = 1'b0; ve[7] = {1'b0, 16'hFFFF};
    va[8] = 16'h0100; vb[8] = 16'h0100; vc[8] = 1'b1; vs[8] = 1'b1; ve[8] = {1'b1, 16'h0000};
    va[9] = 16'h7FFF; vb[9] = 16'h7FFF; vc[9] = 1'b0; vs[9] = 1'b0; ve[9] = {1'b0, 16'hFFFE};
    idx = 0; got = 0; t = 0; held_valid = 1'b0; held_sum = 16'h0000;
    while ((idx < 10 || exp_q.size() != 0) && t < 60) begin
      ready_i = !(t >= 6 && t <= 10);
      #1;
      if (valid_o && ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra got s=%h exp no result", sum);
        end else begin
          if ({cout, sum} !== exp_q[0]) begin
            errors++; $display("FAIL bp_result_%0d got %h exp %h", got, {cout, sum}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        got++;
      end
      if (valid_o && !ready_i) begin
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", ready_o); end
        if (held_valid) begin
          checks++;
          if (sum !== held_sum) begin errors++; $display("FAIL bp_hold got %h exp %h", sum, held_sum); end
        end
        held_valid = 1'b1;
        held_sum   = sum;
      end else begin
        held_valid = 1'b0;
      end
      if (ready_o && idx < 10) begin
        valid_i = 1'b1; a = va[idx]; b = vb[idx]; cin = vc[idx]; sub = vs[idx];
        exp_q.push_back(ve[idx]);
        idx++;
      end else begin
        valid_i = 1'b0;
      end
      tick();
      t++;
    end
    checks++;
    if (got != 10 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_count got %0d results (%0d pending) exp 10 (0)", got, exp_q.size());
    end
    sub = 1'b0;
    drain();
  endtask

  task automatic test_reset_midflight();
    for (int t = 0; t < 3; t++) begin
      valid_i = 1'b1; a = 16'(16'h1111 * (t + 1)); b = 16'h0001; cin = 1'b0; sub = 1'b0;
      tick();
    end
    valid_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({valid_o, ready_o, sum} !== {1'b0, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL rst_mid got v=%b r=%b s=%h exp 0 1 0000", valid_o, ready_o, sum);
    end
    for (int t = 0; t < 6; t++) begin
      tick();
      checks++;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_stale_%0d got valid=%b exp 0", t, valid_o); end
    end
    valid_i = 1'b1; a = 16'h0010; b = 16'h0020; cin = 1'b0; sub = 1'b0;
    tick();
    valid_i = 1'b0;
    tick();
    tick();
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_after_early got valid=%b exp 0", valid_o); end
    tick();
    checks++;
    if ({valid_o, cout, ovf, sum} !== {1'b1, 1'b0, 1'b0, 16'h0030}) begin
      errors++; $display("FAIL rst_after_result got v=%b c=%b o=%b s=%h exp 1 0 0 0030", valid_o, cout, ovf, sum);
    end
    drain();
  endtask

`ifdef PIPELINE_ADDSUB_SAT_EN
  task automatic test_saturate();
    logic        tsat [3];
    logic [15:0] ta [3];
    logic        ts [3];
    logic [16:0] te [3];
    tsat[0] = 1'b1; ta[0] = 16'h7FFF; ts[0] = 1'b0; te[0] = {1'b1, 16'h7FFF};
    tsat[1] = 1'b0; ta[1] = 16'h7FFF; ts[1] = 1'b0; te[1] = {1'b1, 16'h8000};
    tsat[2] = 1'b1; ta[2] = 16'h8000; ts[2] = 1'b1; te[2] = {1'b1, 16'h8000};
    for (int t = 0; t < 7; t++) begin
      if (t >= 4) begin
        checks++;
        if ({valid_o, ovf, sum} !== {1'b1, te[t-4]}) begin
          errors++; $display("FAIL sat_%0d got v=%b o=%b s=%h exp v=1 {o,s}=%h", t - 4, valid_o, ovf, sum, te[t-4]);
        end
      end
      if (t < 3) begin
        valid_i = 1'b1; a = ta[t]; b = 16'h0001; cin = 1'b0; sub = ts[t]; sat = tsat[t];
      end else begin
        valid_i = 1'b0;
      end
      tick();
    end
    sub = 1'b0; sat = 1'b0;
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_add_ripple();
    test_back_to_back();
    test_subtract();
    test_backpressure();
    test_reset_midflight();
`ifdef PIPELINE_ADDSUB_SAT_EN
    test_saturate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipeline_addsub.md
Name: pipeline_addsub

Overview:
- Parametrised pipelined ripple-chunk adder/subtractor, successor to the fixed 8-bit two-stage adder.
- Operand width and stage count are generic; each stage adds one chunk of P_DATA_WIDTH/P_STAGES bits and forwards its carry to the next stage.
- Adds per-transaction add/sub mode, signed-overflow flag, and a valid/ready handshake with backpressure.
- Used on DDSM accumulator/error-feedback paths where wide adds must close timing at full clock rate.

Parameters:
- P_DATA_WIDTH, 16, operand/result width in bits; must be divisible by P_STAGES.
- P_STAGES, 4, number of pipeline stages (1..P_DATA_WIDTH); chunk width CW = P_DATA_WIDTH/P_STAGES.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_valid  input  1  input transaction valid.
- o_ready  output  1  block can accept input this cycle.
- i_a  input  P_DATA_WIDTH  operand A.
- i_b  input  P_DATA_WIDTH  operand B.
- i_cin  input  1  carry-in; ignored when i_sub=1.
- i_sub  input  1  0: A+B+cin; 1: A-B, computed as A+~B+1.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_sum  output  P_DATA_WIDTH  result, mod 2^P_DATA_WIDTH.
- o_cout  output  1  carry out of the MSB; in subtract mode 1 means no borrow (A>=B unsigned).
- o_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - All stage valid bits, o_valid, o_sum, o_cout and o_ovf go to 0.
  - All skew registers clear; in-flight transactions are discarded.
  - o_ready is 1 in the first cycle after reset.
- Advance enable: en = ~o_valid | i_ready; o_ready = en (combinational).
  - When en=0, every stage register holds its value; nothing is lost or duplicated.
- Accept when i_valid & o_ready at a rising edge.
  - Stage 0 registers chunk 0 sum, its carry, the valid bit, and the mode bit.
  - Stage 0 also registers the remaining A chunks and the B chunks (B already inverted when i_sub=1).
- Stage k (1..P_STAGES-1):
  - Adds chunk k of the delayed operands plus the stage k-1 carry.
  - Forwards all lower result chunks unchanged, plus the new carry and the valid bit.
- Effective carry-in = i_sub ? 1 : i_cin.
- Latency: result is on o_sum, o_cout and o_ovf with o_valid=1 exactly P_STAGES cycles after acceptance when no stall occurs. Throughput is one transaction per cycle.
- Outputs are registered: the last stage register drives o_sum, o_cout, o_ovf and o_valid.
- o_ovf is computed in the last stage from the carry into bit P_DATA_WIDTH-1 and the carry out of it.
- Bubbles (i_valid=0) propagate as valid=0 slots. Bubbles are not collapsed, so a stall holds bubbles as well.
- Result fields are held stable while o_valid=1 and i_ready=0.
- P_STAGES=1 degenerates to a single registered full-width add with latency 1.
- Simultaneous case: o_valid=1, i_ready=1 and i_valid=1 in one cycle means the output is consumed and a new input is accepted in the same cycle.
- Elaboration check: if P_DATA_WIDTH % P_STAGES != 0, raise a fatal error with $error in a generate block.

Optional Feature:
- Macro: PIPELINE_ADDSUB_SAT_EN.
- Defined:
  - Adds input port i_sat (1 bit), captured with the transaction and carried down the pipeline.
  - If the captured i_sat=1 and signed overflow occurs, o_sum is clamped in the last stage. Positive overflow gives 0x7FF..F; negative overflow gives 0x800..0.
  - o_ovf still reports the overflow. Latency is unchanged.
- Undefined: port i_sat is absent and o_sum always wraps modulo 2^P_DATA_WIDTH.

Test Plan:
- Defaults (16,4), i_ready=1: A=0x00FF, B=0x0001, cin=0, add -> after 4 cycles o_valid=1, o_sum=0x0100, o_cout=0, o_ovf=0. The carry ripples across chunk boundaries.
- Back-to-back stream: 8 consecutive adds with A=i, B=0xFFFF, cin=1 -> 8 consecutive o_valid cycles, each o_sum=i, o_cout=1, in order, first result 4 cycles after first accept.
- Subtract: A=0x0003, B=0x0005, sub=1 -> o_sum=0xFFFE, o_cout=0 (borrow), o_ovf=0. A=0x8000, B=0x0001, sub=1 -> o_sum=0x7FFF, o_ovf=1.
- Backpressure: hold i_ready=0 for 5 cycles mid-stream -> o_ready=0 once o_valid=1. o_sum is stable and no transaction is lost or duplicated after release. Compare against a scoreboard.
- Reset mid-operation: assert i_rst for 1 cycle with 3 transactions in flight -> o_valid=0 next cycle, no stale results emerge, and the next accepted add appears after 4 cycles.
- With PIPELINE_ADDSUB_SAT_EN: A=0x7FFF, B=0x0001, add, i_sat=1 -> o_sum=0x7FFF, o_ovf=1. Same with i_sat=0 -> o_sum=0x8000, o_ovf=1.
